// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses instruction memory and fills the IF/ID register.
// Handles stall, redirect, flush and sticky out-of-range fetch faults.
module instruction_fetch_unit #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter logic [31:0] NOP_WORD   = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        flush,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        fetch_fault,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ipc4_q, ipc4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] pc_plus4_s;
  logic        pc_oor_s;
  logic        target_ok_s;

  assign pc_plus4_s  = pc_q + 32'd4;
  assign pc_oor_s    = (pc_q >> (ADDR_WIDTH + 2)) != 32'd0;
  assign target_ok_s = (redirect_pc >> (ADDR_WIDTH + 2)) == 32'd0;

  // Next-state and next-IF/ID computation
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    valid_d = valid_q;
    fault_d = fault_q;
    case (state_q)
      BOOT: begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else if (stall) begin
          if (flush) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
          end else begin
            instr_d = instr_q;
            valid_d = valid_q;
          end
        end else if (pc_oor_s) begin
          // Any advancing fetch from an unmapped word traps; pc stays on the faulting address
          fault_d = 1'b1;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          state_d = FAULT;
        end else if (flush) begin
          pc_d    = pc_plus4_s;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end else begin
          pc_d    = pc_plus4_s;
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          ipc4_d  = pc_plus4_s;
          valid_d = 1'b1;
        end
      end
      FAULT: begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
        if (redirect && target_ok_s) begin
          pc_d    = redirect_pc;
          state_d = RUN;
        end else begin
          pc_d    = pc_q;
          state_d = FAULT;
        end
      end
      default: begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
        state_d = BOOT;
      end
    endcase
  end

  // State and IF/ID registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      ipc_q   <= 32'd0;
      ipc4_q  <= 32'd0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign imem_addr   = {2'b00, pc_q[31:2]};
  assign ifid_instr  = instr_q;
  assign ifid_pc     = ipc_q;
  assign ifid_pc4    = ipc4_q;
  assign ifid_valid  = valid_q;
  assign fetch_fault = fault_q;
  assign pc          = pc_q;

endmodule
